sdram_arbiter: RTL and testbench
================================

// Module: sdram_arbiter
// PURPOSE
//  Command arbiter sitting directly downstream of the SDRAM init, auto-refresh, write and read engines.
//  Grants the shared SDRAM command/address bus to one engine at a time.
//  Grants are issued via single-cycle enable pulses; the arbiter waits for that engine's done pulse.
//  The granted engine's cmds/addr/ba are muxed onto the PHY. Priority: refresh > write/read (round-robin).
// PARAMETERS
//  TIMEOUT   256  max cycles a grant may last without its done pulse before forced release
// PORTS
//  clk         in   1   system clock, 100 MHz
//  rst         in   1   synchronous, active-high reset
//  init_done   in   1   level, init engine finished
//  init_cmds   in   4   init engine command {cs_n,ras_n,cas_n,we_n}
//  init_addr   in   11  init engine address
//  init_ba     in   2   init engine bank
//  atref_req   in   1   refresh request (level)
//  atref_done  in   1   refresh done pulse
//  atref_cmds  in   4   refresh command
//  atref_addr  in   11  refresh address
//  atref_ba    in   2   refresh bank
//  wr_req / rd_req     in   1   write / read burst request (level)
//  wr_done / rd_done   in   1   write / read done pulse
//  wr_cmds / rd_cmds   in   4   write / read command
//  wr_addr / rd_addr   in   11  write / read address
//  wr_ba / rd_ba       in   2   write / read bank
//  atref_en    out  1   refresh grant pulse
//  wr_en       out  1   write grant pulse
//  rd_en       out  1   read grant pulse
//  sdr_cmds    out  4   PHY command
//  sdr_addr    out  11  PHY address
//  sdr_ba      out  2   PHY bank
//  arb_err     out  1   one-cycle pulse on grant timeout
// BEHAVIOUR
//  States:
//   ST_INIT  -> ST_ARB when init_done=1.
//   ST_ARB   -> ST_AREF if atref_req=1;
//            else if wr_req=1 and rd_req=1, go to the engine NOT served last (last_wr flag);
//            else if wr_req=1 -> ST_WRITE; else if rd_req=1 -> ST_READ; else stay.
//   ST_AREF / ST_WRITE / ST_READ -> ST_ARB on the matching done=1, or on timeout.
//  Timeout: tmo_cnt clears on grant entry and increments each cycle in a grant state.
//   At tmo_cnt==TIMEOUT-1 with no done: go to ST_ARB and pulse arb_err=1 for one cycle.
//  Requests are sampled only in ST_ARB; ST_ARB lasts >=1 cycle between grants.
//  Done pulses are ignored outside their own grant state.
//  Enables are registered. x_en=1 only in the first cycle of the matching grant state:
//   asserted the cycle after ST_ARB sampled the request; exactly one cycle wide.
//  last_wr: set on entry to ST_WRITE, cleared on entry to ST_READ; unchanged by refresh.
//   Resets to 0, so write wins the first tie.
//  PHY mux is combinational on state:
//   ST_INIT=init_*, ST_AREF=atref_*, ST_WRITE=wr_*, ST_READ=rd_*.
//   ST_ARB drives cmds=4'b0111 (NOP), addr=11'h7FF, ba=2'b00.
//  Reset (any cycle, including mid-grant): state=ST_INIT, atref_en/wr_en/rd_en=0, arb_err=0,
//   tmo_cnt=0, last_wr=0; sdr_* follow init_*.
//  tmo_cnt width: $clog2(TIMEOUT); TIMEOUT>=2.
// TESTING
//  Reset, then init_done=1 -> ST_ARB next cycle.
//   sdr_cmds=4'b0111 and sdr_addr=11'h7FF while idle; all en=0.
//  atref_req and wr_req both high in ST_ARB -> atref_en pulses 1 cycle, wr_en stays 0.
//   After atref_done, one idle ST_ARB cycle, then wr_en pulse.
//  wr_req and rd_req held high continuously, done pulses 5 cycles after each en
//   -> grants alternate W,R,W,R starting with W.
//  In ST_WRITE, drive wr_cmds=4'b0100 -> sdr_cmds=4'b0100 same cycle.
//   Spurious rd_done during ST_WRITE -> no state change.
//  Grant rd with rd_done never asserted, TIMEOUT=16 -> return to ST_ARB after 16 cycles.
//   arb_err=1 for exactly one cycle.
//  rst=1 asserted mid-ST_AREF -> next cycle ST_INIT, atref_en=0, sdr_* equal init_*.

Source files
------------

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - grants the shared SDRAM command bus to refresh, write or read engines
module sdram_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic [3:0]  init_cmds,
  input  logic [10:0] init_addr,
  input  logic [1:0]  init_ba,
  input  logic        atref_req,
  input  logic        atref_done,
  input  logic [3:0]  atref_cmds,
  input  logic [10:0] atref_addr,
  input  logic [1:0]  atref_ba,
  input  logic        wr_req,
  input  logic        wr_done,
  input  logic [3:0]  wr_cmds,
  input  logic [10:0] wr_addr,
  input  logic [1:0]  wr_ba,
  input  logic        rd_req,
  input  logic        rd_done,
  input  logic [3:0]  rd_cmds,
  input  logic [10:0] rd_addr,
  input  logic [1:0]  rd_ba,
  output logic        atref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic [3:0]  sdr_cmds,
  output logic [10:0] sdr_addr,
  output logic [1:0]  sdr_ba,
  output logic        arb_err
);

  localparam int TW = $clog2(TIMEOUT);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_AREF  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          last_wr_q, last_wr_d;
  logic          atref_en_q, atref_en_d;
  logic          wr_en_q, wr_en_d;
  logic          rd_en_q, rd_en_d;
  logic          arb_err_q, arb_err_d;
  logic          grant_done;

  // Next-state logic: arbitration in ST_ARB, done/timeout release in grant states
  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    last_wr_d  = last_wr_q;
    atref_en_d = 1'b0;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    arb_err_d  = 1'b0;
    grant_done = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_done) state_d = ST_ARB;
      end
      ST_ARB: begin
        // Counter is held at zero here so every grant starts from a clean count
        tmo_cnt_d = '0;
        if (atref_req) begin
          state_d    = ST_AREF;
          atref_en_d = 1'b1;
        end else if (wr_req && (!rd_req || !last_wr_q)) begin
          state_d   = ST_WRITE;
          wr_en_d   = 1'b1;
          last_wr_d = 1'b1;
        end else if (rd_req) begin
          state_d   = ST_READ;
          rd_en_d   = 1'b1;
          last_wr_d = 1'b0;
        end
      end
      ST_AREF, ST_WRITE, ST_READ: begin
        // Only the done pulse of the engine currently holding the bus counts
        case (state_q)
          ST_AREF:  grant_done = atref_done;
          ST_WRITE: grant_done = wr_done;
          default:  grant_done = rd_done;
        endcase
        if (grant_done) begin
          state_d = ST_ARB;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = ST_ARB;
          arb_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State, counter, round-robin flag and registered pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      tmo_cnt_q  <= '0;
      last_wr_q  <= 1'b0;
      atref_en_q <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      arb_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      last_wr_q  <= last_wr_d;
      atref_en_q <= atref_en_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      arb_err_q  <= arb_err_d;
    end
  end

  // PHY mux follows the current owner; idle arbitration drives a NOP
  always_comb begin
    sdr_cmds = 4'b0111;
    sdr_addr = 11'h7FF;
    sdr_ba   = 2'b00;
    case (state_q)
      ST_INIT: begin
        sdr_cmds = init_cmds;
        sdr_addr = init_addr;
        sdr_ba   = init_ba;
      end
      ST_AREF: begin
        sdr_cmds = atref_cmds;
        sdr_addr = atref_addr;
        sdr_ba   = atref_ba;
      end
      ST_WRITE: begin
        sdr_cmds = wr_cmds;
        sdr_addr = wr_addr;
        sdr_ba   = wr_ba;
      end
      ST_READ: begin
        sdr_cmds = rd_cmds;
        sdr_addr = rd_addr;
        sdr_ba   = rd_ba;
      end
      default: begin
        sdr_cmds = 4'b0111;
        sdr_addr = 11'h7FF;
        sdr_ba   = 2'b00;
      end
    endcase
  end

  assign atref_en = atref_en_q;
  assign wr_en    = wr_en_q;
  assign rd_en    = rd_en_q;
  assign arb_err  = arb_err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed testbench for sdram_arbiter
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic [3:0]  init_cmds;
  logic [10:0] init_addr;
  logic [1:0]  init_ba;
  logic        atref_req, atref_done;
  logic [3:0]  atref_cmds;
  logic [10:0] atref_addr;
  logic [1:0]  atref_ba;
  logic        wr_req, wr_done;
  logic [3:0]  wr_cmds;
  logic [10:0] wr_addr;
  logic [1:0]  wr_ba;
  logic        rd_req, rd_done;
  logic [3:0]  rd_cmds;
  logic [10:0] rd_addr;
  logic [1:0]  rd_ba;
  logic        atref_en, wr_en, rd_en;
  logic [3:0]  sdr_cmds;
  logic [10:0] sdr_addr;
  logic [1:0]  sdr_ba;
  logic        arb_err;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .init_done(init_done), .init_cmds(init_cmds), .init_addr(init_addr), .init_ba(init_ba),
    .atref_req(atref_req), .atref_done(atref_done), .atref_cmds(atref_cmds),
    .atref_addr(atref_addr), .atref_ba(atref_ba),
    .wr_req(wr_req), .wr_done(wr_done), .wr_cmds(wr_cmds), .wr_addr(wr_addr), .wr_ba(wr_ba),
    .rd_req(rd_req), .rd_done(rd_done), .rd_cmds(rd_cmds), .rd_addr(rd_addr), .rd_ba(rd_ba),
    .atref_en(atref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdr_cmds(sdr_cmds), .sdr_addr(sdr_addr), .sdr_ba(sdr_ba), .arb_err(arb_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init_done = 1'b0;
    tick();
    tick();
    n_checks++;
    if (sdr_cmds !== 4'b0001 || sdr_addr !== 11'h101 || sdr_ba !== 2'b01) begin
      n_fails++;
      $display("FAIL reset_phy: got %b/%h/%b expected 0001/101/01", sdr_cmds, sdr_addr, sdr_ba);
    end
    n_checks++;
    if ({atref_en, wr_en, rd_en, arb_err} !== 4'b0000) begin
      n_fails++;
      $display("FAIL reset_outputs: got %b expected 0000", {atref_en, wr_en, rd_en, arb_err});
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (sdr_cmds !== 4'b0001) begin
      n_fails++;
      $display("FAIL hold_init: got %b expected 0001", sdr_cmds);
    end
    init_done = 1'b1;
    tick();
    n_checks++;
    if (sdr_cmds !== 4'b0111 || sdr_addr !== 11'h7FF || sdr_ba !== 2'b00) begin
      n_fails++;
      $display("FAIL arb_nop: got %b/%h/%b expected 0111/7ff/00", sdr_cmds, sdr_addr, sdr_ba);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (sdr_cmds !== 4'b0111 || {atref_en, wr_en, rd_en} !== 3'b000) begin
        n_fails++;
        $display("FAIL idle_%0d: got cmds %b en %b expected 0111 en 000", i, sdr_cmds,
                 {atref_en, wr_en, rd_en});
      end
    end
  endtask

  task automatic test_refresh_priority();
    atref_req = 1'b1;
    wr_req = 1'b1;
    tick();
    n_checks++;
    if ({atref_en, wr_en, rd_en} !== 3'b100 || sdr_cmds !== 4'b0010) begin
      n_fails++;
      $display("FAIL aref_grant: got en %b cmds %b expected 100 0010", {atref_en, wr_en, rd_en}, sdr_cmds);
    end
    atref_req = 1'b0;
    tick();
    n_checks++;
    if (atref_en !== 1'b0 || sdr_cmds !== 4'b0010) begin
      n_fails++;
      $display("FAIL aref_pulse_width: got en %b cmds %b expected 0 0010", atref_en, sdr_cmds);
    end
    atref_done = 1'b1;
    tick();
    atref_done = 1'b0;
    n_checks++;
    if (sdr_cmds !== 4'b0111 || wr_en !== 1'b0) begin
      n_fails++;
      $display("FAIL aref_release: got cmds %b wr_en %b expected 0111 0", sdr_cmds, wr_en);
    end
    tick();
    wr_req = 1'b0;
    n_checks++;
    if (wr_en !== 1'b1 || sdr_cmds !== 4'b0011) begin
      n_fails++;
      $display("FAIL wr_after_aref: got wr_en %b cmds %b expected 1 0011", wr_en, sdr_cmds);
    end
  endtask

  task automatic test_write_passthrough();
    wr_cmds = 4'b0100;
    #1;
    n_checks++;
    if (sdr_cmds !== 4'b0100 || sdr_addr !== 11'h303 || sdr_ba !== 2'b11) begin
      n_fails++;
      $display("FAIL wr_mux: got %b/%h/%b expected 0100/303/11", sdr_cmds, sdr_addr, sdr_ba);
    end
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    n_checks++;
    if (sdr_cmds !== 4'b0100 || wr_en !== 1'b0) begin
      n_fails++;
      $display("FAIL spurious_rd_done: got cmds %b wr_en %b expected 0100 0", sdr_cmds, wr_en);
    end
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    wr_cmds = 4'b0011;
    n_checks++;
    if (sdr_cmds !== 4'b0111) begin
      n_fails++;
      $display("FAIL wr_release: got %b expected 0111", sdr_cmds);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_grant [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    bit seen;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        tick();
        if (atref_en || wr_en || rd_en) seen = 1'b1;
      end
      n_checks++;
      if (!seen || {wr_en, rd_en} !== exp_grant[g] || atref_en !== 1'b0) begin
        n_fails++;
        $display("FAIL rr_grant_%0d: got wr/rd %b seen %0d expected %b", g, {wr_en, rd_en}, seen, exp_grant[g]);
      end
      repeat (4) tick();
      if (exp_grant[g] == 2'b10) wr_done = 1'b1;
      else rd_done = 1'b1;
      tick();
      wr_done = 1'b0;
      rd_done = 1'b0;
      if (g == 3) begin
        wr_req = 1'b0;
        rd_req = 1'b0;
      end
    end
    tick();
    n_checks++;
    if (sdr_cmds !== 4'b0111) begin
      n_fails++;
      $display("FAIL rr_idle_after: got %b expected 0111", sdr_cmds);
    end
  endtask

  task automatic test_timeout();
    int n;
    int err_seen_early;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    n_checks++;
    if (rd_en !== 1'b1 || sdr_cmds !== 4'b0101) begin
      n_fails++;
      $display("FAIL tmo_grant: got rd_en %b cmds %b expected 1 0101", rd_en, sdr_cmds);
    end
    n = 0;
    err_seen_early = 0;
    while (sdr_cmds !== 4'b0111 && n < 40) begin
      if (arb_err) err_seen_early++;
      tick();
      n++;
    end
    n_checks++;
    if (n != 16) begin
      n_fails++;
      $display("FAIL tmo_length: got %0d cycles expected 16", n);
    end
    n_checks++;
    if (arb_err !== 1'b1 || err_seen_early != 0) begin
      n_fails++;
      $display("FAIL tmo_err_assert: got arb_err %b early %0d expected 1 0", arb_err, err_seen_early);
    end
    tick();
    n_checks++;
    if (arb_err !== 1'b0) begin
      n_fails++;
      $display("FAIL tmo_err_width: got %b expected 0", arb_err);
    end
  endtask

  task automatic test_reset_mid_grant();
    atref_req = 1'b1;
    tick();
    atref_req = 1'b0;
    tick();
    n_checks++;
    if (sdr_cmds !== 4'b0010) begin
      n_fails++;
      $display("FAIL mid_aref_state: got %b expected 0010", sdr_cmds);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (sdr_cmds !== 4'b0001 || sdr_addr !== 11'h101 || sdr_ba !== 2'b01 || atref_en !== 1'b0) begin
      n_fails++;
      $display("FAIL mid_aref_reset: got %b/%h/%b en %b expected 0001/101/01 en 0",
               sdr_cmds, sdr_addr, sdr_ba, atref_en);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    init_done = 1'b0;
    init_cmds = 4'b0001;  init_addr = 11'h101;  init_ba = 2'b01;
    atref_req = 1'b0;  atref_done = 1'b0;
    atref_cmds = 4'b0010; atref_addr = 11'h202; atref_ba = 2'b10;
    wr_req = 1'b0;  wr_done = 1'b0;
    wr_cmds = 4'b0011;  wr_addr = 11'h303;  wr_ba = 2'b11;
    rd_req = 1'b0;  rd_done = 1'b0;
    rd_cmds = 4'b0101;  rd_addr = 11'h404;  rd_ba = 2'b01;

    test_reset();
    test_idle();
    test_refresh_priority();
    test_write_passthrough();
    test_back_to_back();
    test_timeout();
    test_reset_mid_grant();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
